// File: rtl/coin_defs.sv
// Shared constants, FSM encodings and the refund helper
// for the coin acceptor front-end.
package coin_defs;

  localparam int unsigned DEF_COIN_W     = 4;
  localparam int unsigned DEF_CREDIT_W   = 8;
  localparam int unsigned DEF_DENOM_A    = 1;
  localparam int unsigned DEF_DENOM_B    = 5;
  localparam int unsigned DEF_DENOM_C    = 10;
  localparam int unsigned DEF_MAX_CREDIT = 99;
  localparam int unsigned DEF_REFUND_GAP = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic logic [15:0] largest_denom(
    input logic [15:0] credit,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c
  );
    logic [15:0] d;
    d = '0;
    if (credit >= c)
      d = c;
    else if (credit >= b)
      d = b;
    else if (credit >= a)
      d = a;
    return d;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin slot, vend controller and refund signals
// of the coin acceptor.
interface coin_acceptor_if #(
  parameter int unsigned COIN_W   = 4,
  parameter int unsigned CREDIT_W = 8
);

  logic                coin_strobe;
  logic [COIN_W-1:0]   coin_input;
  logic                coin_accept;
  logic                coin_reject;
  logic [COIN_W-1:0]   coin_value;
  logic [CREDIT_W-1:0] credit;
  logic                charge_req;
  logic [CREDIT_W-1:0] charge_amount;
  logic                charge_ack;
  logic                charge_nack;
  logic                refund_req;
  logic                refund_busy;
  logic                refund_coin_strobe;
  logic [COIN_W-1:0]   refund_coin_value;
  logic                refund_done;

  modport master (
    output coin_strobe, coin_input,
    output charge_req, charge_amount,
    output refund_req,
    input  coin_accept, coin_reject, coin_value,
    input  credit, charge_ack, charge_nack,
    input  refund_busy, refund_coin_strobe,
    input  refund_coin_value, refund_done
  );

  modport slave (
    input  coin_strobe, coin_input,
    input  charge_req, charge_amount,
    input  refund_req,
    output coin_accept, coin_reject, coin_value,
    output credit, charge_ack, charge_nack,
    output refund_busy, refund_coin_strobe,
    output refund_coin_value, refund_done
  );

endinterface

// File: rtl/coin_validator.sv
// Combinational check of a coin against the three
// legal denominations.
module coin_validator #(
  parameter int unsigned COIN_W  = 4,
  parameter int unsigned DENOM_A = 1,
  parameter int unsigned DENOM_B = 5,
  parameter int unsigned DENOM_C = 10
) (
  input  logic [COIN_W-1:0] coin_input,
  output logic              is_legal
);

  always_comb begin
    is_legal = 1'b0;
    unique case (coin_input)
      COIN_W'(DENOM_A): is_legal = 1'b1;
      COIN_W'(DENOM_B): is_legal = 1'b1;
      COIN_W'(DENOM_C): is_legal = 1'b1;
      default:          is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front-end: validates coins, keeps credit, serves
// charges and refunds credit as a timed coin sequence.
module coin_acceptor
  import coin_defs::*;
#(
  parameter int unsigned COIN_W     = DEF_COIN_W,
  parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
  parameter int unsigned DENOM_A    = DEF_DENOM_A,
  parameter int unsigned DENOM_B    = DEF_DENOM_B,
  parameter int unsigned DENOM_C    = DEF_DENOM_C,
  parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int unsigned REFUND_GAP = DEF_REFUND_GAP
) (
  input  logic           clk,
  input  logic           rst_n,
  coin_acceptor_if.slave bus
);

  localparam int unsigned GAP_W =
    (REFUND_GAP > 1) ? $clog2(REFUND_GAP) : 1;

  logic [1:0]          state, state_n;
  logic [GAP_W-1:0]    cnt, cnt_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  logic [CREDIT_W-1:0] post, sum, ld, rem;
  logic [CREDIT_W:0]   room;
  logic                legal, idle, emit;
  logic                accept_n, reject_n;
  logic                ack_n, nack_n;
  logic                strobe_n, done_n;
  logic [COIN_W-1:0]   value_n, rvalue_n;

  coin_validator #(
    .COIN_W (COIN_W),
    .DENOM_A(DENOM_A),
    .DENOM_B(DENOM_B),
    .DENOM_C(DENOM_C)
  ) u_validator (
    .coin_input(bus.coin_input),
    .is_legal  (legal)
  );

  assign bus.credit = credit;

  always_comb begin
    idle     = (state == ST_IDLE);
    state_n  = state;
    cnt_n    = cnt;
    accept_n = 1'b0;
    reject_n = 1'b0;
    value_n  = '0;
    ack_n    = 1'b0;
    nack_n   = 1'b0;
    strobe_n = 1'b0;
    rvalue_n = '0;
    done_n   = 1'b0;
    emit     = 1'b0;

    post = credit;
    if (bus.charge_req) begin
      if (idle && credit >= bus.charge_amount) begin
        ack_n = 1'b1;
        post  = credit - bus.charge_amount;
      end else begin
        nack_n = 1'b1;
      end
    end

    // overflow check runs on the post-charge credit
    room = {1'b0, post}
         + (CREDIT_W+1)'(bus.coin_input);
    sum  = post;
    if (bus.coin_strobe) begin
      if (idle && legal &&
          room <= (CREDIT_W+1)'(MAX_CREDIT)) begin
        accept_n = 1'b1;
        value_n  = bus.coin_input;
        sum      = room[CREDIT_W-1:0];
      end else begin
        reject_n = 1'b1;
      end
    end
    credit_n = sum;

    case (state)
      ST_IDLE: begin
        if (bus.refund_req && !bus.charge_req) begin
          if (sum == '0)
            done_n = 1'b1;
          else
            emit = 1'b1;
        end
      end
      ST_EMIT: begin
        if (credit == '0) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_GAP;
          cnt_n   = GAP_W'(REFUND_GAP - 1);
        end
      end
      ST_GAP: begin
        if (cnt == '0)
          emit = 1'b1;
        else
          cnt_n = cnt - GAP_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase

    ld  = CREDIT_W'(largest_denom(16'(sum),
            16'(DENOM_A), 16'(DENOM_B),
            16'(DENOM_C)));
    rem = sum - ld;

    // a remainder below DENOM_A is forfeited
    if (emit) begin
      if (ld == '0) begin
        credit_n = '0;
        done_n   = 1'b1;
        state_n  = ST_IDLE;
      end else begin
        credit_n = rem;
        strobe_n = 1'b1;
        rvalue_n = COIN_W'(ld);
        done_n   = (rem == '0);
        state_n  = ST_EMIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= ST_IDLE;
      cnt                    <= '0;
      credit                 <= '0;
      bus.coin_accept        <= 1'b0;
      bus.coin_reject        <= 1'b0;
      bus.coin_value         <= '0;
      bus.charge_ack         <= 1'b0;
      bus.charge_nack        <= 1'b0;
      bus.refund_busy        <= 1'b0;
      bus.refund_coin_strobe <= 1'b0;
      bus.refund_coin_value  <= '0;
      bus.refund_done        <= 1'b0;
    end else begin
      state                  <= state_n;
      cnt                    <= cnt_n;
      credit                 <= credit_n;
      bus.coin_accept        <= accept_n;
      bus.coin_reject        <= reject_n;
      bus.coin_value         <= value_n;
      bus.charge_ack         <= ack_n;
      bus.charge_nack        <= nack_n;
      bus.refund_busy        <= (state_n != ST_IDLE);
      bus.refund_coin_strobe <= strobe_n;
      bus.refund_coin_value  <= rvalue_n;
      bus.refund_done        <= done_n;
    end
  end

endmodule
